// File: rtl/req_encoder_16x4.sv
// req_encoder_16x4: latches a multi-hot request word and emits each set bit's 4-bit index, one per handshake, in priority order.
module req_encoder_16x4 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  index,
  output logic        valid,
  output logic        busy,
  output logic [4:0]  count,
  output logic        done
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [15:0] pending, pending_n;
  logic [4:0] count_n;
  logic done_n;
  assign busy = state == SEND;
  assign valid = busy;
  // Later loop iterations overwrite earlier ones, so the highest-priority bit is visited last.
  always_comb begin
    index = 4'd0;
    for (int i = 0; i < 16; i++)
      if (pending[LSB_FIRST ? 15 - i : i]) index = LSB_FIRST ? 4'(15 - i) : 4'(i);
  end
  always_comb begin
    state_n = state;
    pending_n = pending;
    count_n = count;
    done_n = 1'b0;
    if (state == IDLE && load) begin
      if (req != 16'd0) begin
        pending_n = req;
        count_n = 5'($countones(req));
        state_n = SEND;
      end else
        done_n = 1'b1;
    end else if (state == SEND && ready) begin
      pending_n = pending & ~(16'd1 << index);
      count_n = count - 5'd1;
      state_n = count == 5'd1 ? IDLE : SEND;
      done_n = count == 5'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= 16'd0;
      count <= 5'd0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      count <= count_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_req_encoder_16x4.sv
// tb_req_encoder_16x4: directed plus random stimulus against a queue-based model, for both priority orders.
module tb_req_encoder_16x4;
  logic clk = 1'b0;
  logic reset = 1'b1, load = 1'b0, ready = 1'b0;
  logic [15:0] req = 16'd0;
  logic [3:0] index_l, index_m;
  logic valid_l, valid_m, busy_l, busy_m, done_l, done_m;
  logic [4:0] count_l, count_m;
  int checks = 0, errors = 0;
  int q_lsb[$], q_msb[$];
  bit m_busy = 0, m_done = 0;
  always #5 clk = ~clk;
  req_encoder_16x4 #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .load(load), .req(req), .ready(ready),
    .index(index_l), .valid(valid_l), .busy(busy_l), .count(count_l), .done(done_l));
  req_encoder_16x4 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .load(load), .req(req), .ready(ready),
    .index(index_m), .valid(valid_m), .busy(busy_m), .count(count_m), .done(done_m));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit l, input logic [15:0] d, input bit rd);
    reset = r; load = l; req = d; ready = rd;
    @(posedge clk);
    m_done = 0;
    if (r) begin
      q_lsb.delete(); q_msb.delete(); m_busy = 0;
    end else if (!m_busy) begin
      if (l && d != 16'd0) begin
        for (int i = 0; i < 16; i++)
          if (d[i]) begin q_lsb.push_back(i); q_msb.push_front(i); end
        m_busy = 1;
      end else if (l)
        m_done = 1;
    end else if (rd) begin
      void'(q_lsb.pop_front()); void'(q_msb.pop_front());
      if (q_lsb.size() == 0) begin m_busy = 0; m_done = 1; end
    end
    #1;
    check("valid_l", 16'(valid_l), 16'(m_busy));
    check("busy_l", 16'(busy_l), 16'(m_busy));
    check("done_l", 16'(done_l), 16'(m_done));
    check("count_l", 16'(count_l), 16'(q_lsb.size()));
    check("index_l", 16'(index_l), m_busy ? 16'(q_lsb[0]) : 16'd0);
    check("valid_m", 16'(valid_m), 16'(m_busy));
    check("done_m", 16'(done_m), 16'(m_done));
    check("count_m", 16'(count_m), 16'(q_msb.size()));
    check("index_m", 16'(index_m), m_busy ? 16'(q_msb[0]) : 16'd0);
  endtask
  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 16'h8001, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 16'h4000, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 16'h0120, 0);
    step(0, 0, 0, 0);
    step(0, 1, 16'hFFFF, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 16'hFFFF, 1);
    repeat (17) begin
      if (valid_l) check("roundtrip", 16'd1 << index_l, 16'd1 << q_lsb[0]);
      step(0, 0, 0, 1);
    end
    step(0, 1, 16'h0000, 1);
    step(0, 0, 0, 1);
    step(0, 1, 16'h00F0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 1, 16'h0002, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'($urandom);
        1: d = 16'($urandom & $urandom & $urandom);
        2: d = 16'd1 << $urandom_range(0, 15);
        default: d = 16'd0;
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, d, $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
